// File: rtl/blink_period_meter_if.sv
// Signal bundle between a blink source / result consumer and blink_period_meter.
interface blink_period_meter_if #(
  parameter int WIDTH = 16
);
  logic             sig_in;
  logic             clear;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             overflow;
  logic [1:0]       state_dbg;

  modport master (
    output sig_in, clear,
    input  period, high_time, valid, overflow, state_dbg
  );

  modport slave (
    input  sig_in, clear,
    output period, high_time, valid, overflow, state_dbg
  );
endinterface

// File: rtl/blink_period_meter.sv
// Measures period and high time of an asynchronous blink input in clk cycles,
// with a one-cycle valid strobe and a sticky overflow for lost/slow input.
module blink_period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  blink_period_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   rise;
  logic                   fall;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi_tmp, hi_tmp_n;
  logic [WIDTH-1:0] period_q, period_n;
  logic [WIDTH-1:0] high_q, high_n;
  logic             valid_q, valid_n;
  logic             ovf_q, ovf_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
      prev <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_tmp   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hi_tmp   <= hi_tmp_n;
      period_q <= period_n;
      high_q   <= high_n;
      valid_q  <= valid_n;
      ovf_q    <= ovf_n;
    end
  end

  // Priority: clear, then saturation, then a closing rise, then fall/count.
  // Saturation wins over a rise so an out-of-range period is never reported.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_tmp_n = hi_tmp;
    period_n = period_q;
    high_n   = high_q;
    valid_n  = 1'b0;
    ovf_n    = ovf_q;
    if (bus.clear) begin
      state_n  = IDLE;
      cnt_n    = '0;
      hi_tmp_n = '0;
      period_n = '0;
      high_n   = '0;
      ovf_n    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (rise) begin
            state_n = HIGH;
            cnt_n   = WIDTH'(1);
          end
        end
        HIGH, LOW: begin
          if (cnt == CNT_MAX) begin
            ovf_n   = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
          end else if (rise && state == LOW) begin
            period_n = cnt;
            high_n   = hi_tmp;
            valid_n  = 1'b1;
            cnt_n    = WIDTH'(1);
            state_n  = HIGH;
          end else begin
            cnt_n = cnt + WIDTH'(1);
            if (fall && state == HIGH) begin
              hi_tmp_n = cnt;
              state_n  = LOW;
            end
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign bus.period    = period_q;
  assign bus.high_time = high_q;
  assign bus.valid     = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_blink_period_meter.sv
// Bench for blink_period_meter: 16-bit and 8-bit instances share stimulus and are
// compared every cycle against a timestamp-based reference model.
module tb_blink_period_meter;

  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sig   = 1'b0;
  logic clr   = 1'b0;

  int tests = 0;
  int fails = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  always #5 clk = ~clk;

  blink_period_meter_if #(.WIDTH(16)) if_a ();
  blink_period_meter_if #(.WIDTH(8))  if_b ();

  assign if_a.sig_in = sig;
  assign if_a.clear  = clr;
  assign if_b.sig_in = sig;
  assign if_b.clear  = clr;

  blink_period_meter #(.WIDTH(16), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a.slave)
  );
  blink_period_meter #(.WIDTH(8), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  // Reference model: remembers when the last rise happened and derives
  // period/high time as differences of cycle numbers.
  typedef struct {
    int st;
    int t_rise;
    int hi_len;
    int period;
    int high;
    bit valid;
    bit ovf;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;
  bit   hist [0:131071];
  int   k = 0;
  int   base = 1;

  function automatic bit lvl(int j);
    return (j < base || j < 0) ? 1'b0 : hist[j];
  endfunction

  function automatic mdl_t step(mdl_t a, int t, int maxv, bit r, bit f, bit c);
    mdl_t n = a;
    int   age;
    n.valid = 1'b0;
    if (c) begin
      n.st = 0; n.period = 0; n.high = 0; n.ovf = 1'b0; n.hi_len = 0;
    end else if (a.st == 0) begin
      if (r) begin n.st = 1; n.t_rise = t; end
    end else begin
      age = t - a.t_rise;
      if (age >= maxv) begin
        n.ovf = 1'b1; n.st = 0;
      end else if (r) begin
        n.period = age; n.high = a.hi_len; n.valid = 1'b1; n.t_rise = t; n.st = 1;
      end else if (f) begin
        n.hi_len = age; n.st = 2;
      end
    end
    return n;
  endfunction

  // Edge k+1 closes cycle k; the detected level in that cycle is the input
  // sampled S-1 edges earlier, and the previous level one edge before that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma   <= '{default: 0};
      mb   <= '{default: 0};
      base <= k + 1;
    end else begin
      k           <= k + 1;
      hist[k + 1] <= sig;
      ma <= step(ma, k, 65535, lvl(k + 1 - S) & ~lvl(k - S), ~lvl(k + 1 - S) & lvl(k - S), clr);
      mb <= step(mb, k, 255,   lvl(k + 1 - S) & ~lvl(k - S), ~lvl(k + 1 - S) & lvl(k - S), clr);
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      check("model_a",
            {if_a.period, if_a.high_time, if_a.valid, if_a.overflow, if_a.state_dbg},
            {16'(ma.period), 16'(ma.high), ma.valid, ma.ovf, 2'(ma.st)});
      check("model_b",
            {if_b.period, if_b.high_time, if_b.valid, if_b.overflow, if_b.state_dbg},
            {8'(mb.period), 8'(mb.high), mb.valid, mb.ovf, 2'(mb.st)});
      pulses_a += int'(if_a.valid);
      pulses_b += int'(if_b.valid);
    end
  endtask

  task automatic wave(int hi, int lo, int n);
    for (int p = 0; p < n; p++) begin
      sig = 1'b1; cyc(hi);
      sig = 1'b0; cyc(lo);
    end
  endtask

  typedef struct {
    int hi;
    int lo;
    int n;
    int exp_period;
    int exp_high;
    int exp_pulses;
  } row_t;

  row_t rows [4];

  initial begin
    int pa;
    int pb;
    rows[0] = '{5, 7, 4, 12, 5, 3};
    rows[1] = '{3, 1, 6, 4, 3, 5};
    rows[2] = '{1, 1, 5, 2, 1, 4};
    rows[3] = '{10, 1, 3, 11, 10, 2};

    @(negedge clk);
    check("reset_a", {if_a.period, if_a.high_time, if_a.valid, if_a.overflow, if_a.state_dbg}, '0);
    check("reset_b", {if_b.period, if_b.high_time, if_b.valid, if_b.overflow, if_b.state_dbg}, '0);
    #2 rst_n = 1'b1;
    cyc(4);

    // Table-driven square waves, each from a cleared meter.
    for (int i = 0; i < 4; i++) begin
      sig = 1'b0; cyc(4);
      clr = 1'b1; cyc(1); clr = 1'b0;
      pa = pulses_a; pb = pulses_b;
      wave(rows[i].hi, rows[i].lo, rows[i].n);
      cyc(8);
      check("row_period", if_a.period, rows[i].exp_period);
      check("row_high", if_a.high_time, rows[i].exp_high);
      check("row_pulses_a", pulses_a - pa, rows[i].exp_pulses);
      check("row_pulses_b", pulses_b - pb, rows[i].exp_pulses);
    end

    // Saturation on the 8-bit meter after a single rise.
    clr = 1'b1; cyc(1); clr = 1'b0;
    wave(5, 7, 2);
    sig = 1'b1; cyc(3); sig = 1'b0;
    pb = pulses_b;
    cyc(300);
    check("sat_ovf", if_b.overflow, 1);
    check("sat_state", if_b.state_dbg, 0);
    check("sat_period", if_b.period, 12);
    check("sat_high", if_b.high_time, 5);
    check("sat_pulses", pulses_b - pb, 0);
    check("nosat_ovf_a", if_a.overflow, 0);
    pb = pulses_b;
    wave(5, 7, 4);
    cyc(8);
    check("rearm_pulses", pulses_b - pb, 3);
    check("rearm_period", if_b.period, 12);
    check("ovf_sticky", if_b.overflow, 1);
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(1);
    check("clr_ovf", if_b.overflow, 0);
    check("clr_period", if_b.period, 0);

    // Clear on the exact cycle a rise is detected in LOW.
    wave(4, 6, 2);
    pa = pulses_a;
    sig = 1'b1; cyc(S);
    clr = 1'b1; cyc(1); clr = 1'b0;
    check("clrrise_period", if_a.period, 0);
    check("clrrise_high", if_a.high_time, 0);
    check("clrrise_state", if_a.state_dbg, 0);
    check("clrrise_pulses", pulses_a - pa, 0);
    cyc(3); sig = 1'b0; cyc(6);
    pa = pulses_a;
    wave(4, 6, 2);
    cyc(8);
    check("after_clr_pulses", pulses_a - pa, 1);
    check("after_clr_period", if_a.period, 10);
    check("after_clr_high", if_a.high_time, 4);

    // Asynchronous reset in the middle of HIGH.
    sig = 1'b1; cyc(4);
    check("midhigh_state", if_a.state_dbg, 1);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    check("async_rst_a", {if_a.period, if_a.high_time, if_a.valid, if_a.overflow, if_a.state_dbg}, '0);
    check("async_rst_b", {if_b.period, if_b.high_time, if_b.valid, if_b.overflow, if_b.state_dbg}, '0);
    sig = 1'b0; cyc(2);
    #2 rst_n = 1'b1;
    cyc(5);
    pa = pulses_a;
    wave(5, 7, 2);
    cyc(8);
    check("post_rst_pulses", pulses_a - pa, 1);
    check("post_rst_period", if_a.period, 12);

    // Constant high from reset.
    rst_n = 1'b0; sig = 1'b1; cyc(2);
    rst_n = 1'b1;
    pa = pulses_a; pb = pulses_b;
    cyc(1000);
    check("const_ovf_b", if_b.overflow, 1);
    check("const_state_b", if_b.state_dbg, 0);
    check("const_ovf_a", if_a.overflow, 0);
    check("const_state_a", if_a.state_dbg, 1);
    check("const_pulses_a", pulses_a - pa, 0);
    check("const_pulses_b", pulses_b - pb, 0);

    // Randomized waves with occasional long lows and clears.
    sig = 1'b0; cyc(3);
    for (int it = 0; it < 120; it++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(20, 1));
      lo = ($urandom_range(14, 0) == 0) ? int'($urandom_range(300, 250)) : int'($urandom_range(20, 1));
      sig = 1'b1;
      if ($urandom_range(19, 0) == 0) clr = 1'b1;
      cyc(1);
      clr = 1'b0;
      cyc(hi - 1);
      sig = 1'b0;
      cyc(lo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
